// File: rtl/gpio_debounce.sv
// gpio_debounce: two-flop synchronizer and per-pin debounce for eight board
// pins, with sticky rise/fall events, an interrupt enable mask, and a
// three-word register window on the native memory bus.
module gpio_debounce #(
  parameter logic [31:0] ADDR            = 32'h4000_0010,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  pin_raw,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        deb_ready,
  output logic        deb_sel,
  output logic [31:0] deb_rdata,
  output logic [7:0]  pin_stable,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       rise_q, rise_d, fall_q, fall_d;
  logic [7:0]       rise_set, fall_set, rise_clr, fall_clr;
  logic [15:0]      ie_q, ie_d;
  logic [31:0]      rdata_q, rdata_d, rd_mux;
  state_t           state_q, state_d;
  logic             hit_evt, hit_ie, hit_lvl, do_write;

  // Upper write-data bits and strobes 2/3 have no register behind them.
  logic unused_bits;
  assign unused_bits = &{1'b0, mem_wdata[31:16], mem_wstrb[3:2]};

  // Address decode for the three-word window.
  always_comb begin
    hit_evt = (mem_addr == ADDR);
    hit_ie  = (mem_addr == ADDR + 32'd4);
    hit_lvl = (mem_addr == ADDR + 32'd8);
  end

  assign deb_sel    = mem_valid && (hit_evt || hit_ie || hit_lvl);
  assign deb_ready  = (state_q == S_RESP);
  assign deb_rdata  = rdata_q;
  assign pin_stable = stable_q;
  assign irq        = |({fall_q, rise_q} & ie_q);

  // Two-stage synchronizer on the raw pins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pin_raw;
      s2_q <= s1_q;
    end
  end

  // Per-pin debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Register read mux; values are the pre-update snapshot.
  always_comb begin
    rd_mux = '0;
    if (hit_evt)      rd_mux = {16'h0, fall_q, rise_q};
    else if (hit_ie)  rd_mux = {16'h0, ie_q};
    else if (hit_lvl) rd_mux = {24'h0, stable_q};
  end

  // Bus FSM next state, read capture, and register writes.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    ie_d     = ie_q;
    rise_clr = '0;
    fall_clr = '0;
    do_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (deb_sel) begin
          rdata_d  = rd_mux;
          state_d  = S_RESP;
          do_write = (mem_wstrb != 4'b0000);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (do_write && hit_evt) begin
      if (mem_wstrb[0]) rise_clr = mem_wdata[7:0];
      if (mem_wstrb[1]) fall_clr = mem_wdata[15:8];
    end
    if (do_write && hit_ie) begin
      if (mem_wstrb[0]) ie_d[7:0]  = mem_wdata[7:0];
      if (mem_wstrb[1]) ie_d[15:8] = mem_wdata[15:8];
    end
  end

  // Sticky edge events; a hardware set beats a same-cycle clear.
  always_comb begin
    rise_set = stable_d & ~stable_q;
    fall_set = ~stable_d & stable_q;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
  end

  // State registers for debounce, events, IE and the bus FSM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      ie_q     <= '0;
      rdata_q  <= '0;
      state_q  <= S_IDLE;
    end else begin
      stable_q <= stable_d;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      ie_q     <= ie_d;
      rdata_q  <= rdata_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input conditioning stage directly upstream of the GPIO peripheral. It takes eight raw, asynchronous board pins and synchronizes and debounces each one. The debounced value drives the GPIO block's `gpio_pin_in`. It also captures rising and falling edges as sticky, maskable events on `irq`, exposed through a small memory-mapped register window on the same native memory bus as the GPIO block.

## Interface
- `ADDR`, default 32'h4000_0010 — base address of the 3-word register window (ADDR, +4, +8).
- `DEBOUNCE_CYCLES`, default 16 — consecutive mismatching cycles required to accept a new level. Legal range is 1 ≤ DEBOUNCE_CYCLES < 2^CNT_W.
- `CNT_W`, default 8 — per-pin counter width.

- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `pin_raw`  in  8  asynchronous board pins.
- `mem_valid`  in  1  bus request; held by master until `deb_ready`.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `deb_ready`  out  1  one-cycle transaction completion pulse.
- `deb_sel`  out  1  combinational: mem_valid && addr ∈ {ADDR, ADDR+4, ADDR+8}.
- `deb_rdata`  out  32  read data, valid while `deb_ready`=1.
- `pin_stable`  out  8  debounced levels, to GPIO `gpio_pin_in`.
- `irq`  out  1  level interrupt.

## Operation
- **Synchronizer:** two flops per pin (`s1`, `s2`), both reset to 0.
- **Per-pin debounce:** registers `stable[i]` (reset 0) and `cnt[i]` (reset 0).
  - If s2[i]==stable[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=s2[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Any glitch back to the stable level restarts the count. The counter never wraps.
- **Edge events:** `rise[7:0]` and `fall[7:0]` are sticky, reset 0.
  - rise[i] is set on the edge where stable[i] goes 0→1; fall[i] on 1→0.
- **Registers:**
  - ADDR, EVT: read {16'h0, fall, rise}. Write-1-to-clear: mem_wstrb[0] clears rise bits set in wdata[7:0]; mem_wstrb[1] clears fall bits set in wdata[15:8].
  - ADDR+4, IE (reset 0): read {16'h0, ie}. Write: mem_wstrb[0] → ie[7:0], mem_wstrb[1] → ie[15:8]. Strobes 2/3 are ignored.
  - ADDR+8, LVL: read-only {24'h0, stable}. Writes are ignored.
- **Priority:** a hardware set and a W1C on the same bit in the same cycle leaves the bit set.
- **irq** = |({fall, rise} & ie). It is derived only from flops, with no added latency.
- **Bus FSM:** two states, IDLE and RESP; reset to IDLE.
  - IDLE & deb_sel: capture rdata, perform any write, go to RESP.
  - RESP: deb_ready=1, then unconditionally return to IDLE.
  - Requests outside the window are ignored, with ready held at 0.

## Timing
- **Reset values:**
  - pin_stable = 0, irq = 0, deb_ready = 0, deb_rdata = 0.
  - All counters, events and IE = 0.
  - FSM = IDLE; any in-flight transaction is dropped.
- **Input latency:** a raw level sampled at edge k appears on pin_stable at edge k+1+DEBOUNCE_CYCLES, provided it is held steady throughout.
- **Event latency:** the event bit and irq update on the same edge as pin_stable.
- **Bus latency:**
  - Select is seen in cycle n; deb_ready and deb_rdata are valid in cycle n+1; the write takes effect at the end of cycle n.
  - Minimum spacing between transactions is 2 cycles.
- **Read snapshot:** rdata holds the register value before the cycle-n update.
- **Reset mid-transaction:** the write is not performed if resetn=0 in cycle n.

## Test plan
- **Reset:** hold resetn=0 for 3 cycles with pin_raw=8'hFF → pin_stable=0, irq=0, deb_ready=0; pin_stable becomes 8'hFF exactly 1+DEBOUNCE_CYCLES edges after the first edge sampled with resetn=1.
- **Bounce rejection (DEBOUNCE_CYCLES=16):** on pin 3, toggle 0→1 for 10 cycles, then 0 for 1 cycle, then 1 steady → pin_stable[3] rises 17 cycles after the final 1 is sampled; rise[3] is set once; fall[3] stays 0.
- **Events and irq:** write IE=16'h0001, then pulse pin 0 high and later low → irq asserts on the rising transition. Read EVT → 32'h0000_0101. Write 32'h0000_0001 to EVT with wstrb 4'b0001 → rise cleared, irq deasserts, fall[0] remains.
- **Set/clear collision:** issue a W1C to rise[2] in the same cycle stable[2] goes 0→1 → rise[2] stays 1.
- **Bus protocol:** read LVL with pin_stable=8'hA5 → deb_ready pulses for exactly one cycle with rdata 32'h0000_00A5. An access to ADDR+12 → deb_sel=0, no ready. Writing LVL leaves state unchanged.
- **Reset mid-operation:** assert resetn=0 while pin 5's counter is at 10 and a write to IE is in flight → IE=0, cnt=0, FSM=IDLE, no ready pulse.
